// File: rtl/sram_page_allocator_if.sv
// Allocate/free handshake bundle between the page allocator and the
// write path, read path and port scheduler.
interface sram_page_allocator_if #(
   parameter int PAGE_W = 11
);
   logic              ready;
   logic              alloc_vld;
   logic [PAGE_W-1:0] alloc_page;
   logic              alloc_req;
   logic              free_vld;
   logic [PAGE_W-1:0] free_page;
   logic              free_err;
   logic [PAGE_W:0]   free_space;

   // Handshake: a page is granted on a clock edge where alloc_vld and
   // alloc_req are both high; alloc_req without alloc_vld is ignored.
   // free_vld is a one-cycle strobe with no back-pressure, and a rejected
   // free is reported by free_err one cycle later.
   modport master (
      output ready, alloc_vld, alloc_page, free_err, free_space,
      input  alloc_req, free_vld, free_page
   );

   modport slave (
      input  ready, alloc_vld, alloc_page, free_err, free_space,
      output alloc_req, free_vld, free_page
   );
endinterface

// File: rtl/sram_page_allocator.sv
// Free-page manager for one SRAM bank: circular free-page queue, per-page
// in-use bitmap, one allocation and one release per cycle.
module sram_page_allocator #(
   parameter int PAGE_NUM = 2048,
   parameter int PAGE_W   = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_page_allocator_if.master bus,
   output logic                  dbg_state
);
   localparam int CNT_W = PAGE_W + 1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PAGE_W-1:0]   init_idx;
   logic [PAGE_W-1:0]   head;
   logic [PAGE_W-1:0]   tail;
   logic [CNT_W-1:0]    count;
   logic [PAGE_NUM-1:0] bitmap;
   logic [PAGE_W-1:0]   queue [PAGE_NUM];
   logic                free_err_q;

   logic                init_last;
   logic                run;
   logic                offer;
   logic [PAGE_W-1:0]   head_page;
   logic                alloc_go;
   logic                free_ok;
   logic                free_bad;
   logic                wr_en;
   logic [PAGE_W-1:0]   wr_addr;
   logic [PAGE_W-1:0]   wr_data;

   assign init_last = (init_idx == PAGE_W'(PAGE_NUM - 1));
   assign head_page = queue[head];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (init_last) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      run   = (state == ST_RUN);
      offer = run && (count != '0);
   end

   // The free decision uses the bitmap before this edge, so an alloc and a
   // free of the same page in one cycle rejects the free.
   always_comb begin
      alloc_go = offer && bus.alloc_req;
      free_ok  = run && bus.free_vld && bitmap[bus.free_page];
      free_bad = run && bus.free_vld && !bitmap[bus.free_page];
   end

   // Single write port: INIT fills queue[i] = i, RUN appends freed pages.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = tail;
      wr_data = bus.free_page;
      if (!run) begin
         wr_en   = 1'b1;
         wr_addr = init_idx;
         wr_data = init_idx;
      end else if (free_ok) begin
         wr_en   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         queue[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_idx <= '0;
      end else if (!run) begin
         init_idx <= init_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (alloc_go) head <= head + 1'b1;
         if (free_ok)  tail <= tail + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (!run) begin
         if (init_last) count <= CNT_W'(PAGE_NUM);
      end else begin
         count <= count + CNT_W'(free_ok) - CNT_W'(alloc_go);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap <= '0;
      end else begin
         if (free_ok)  bitmap[bus.free_page] <= 1'b0;
         if (alloc_go) bitmap[head_page]     <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         free_err_q <= 1'b0;
      end else begin
         free_err_q <= free_bad;
      end
   end

   assign bus.ready      = run;
   assign bus.alloc_vld  = offer;
   assign bus.alloc_page = head_page;
   assign bus.free_err   = free_err_q;
   assign bus.free_space = count;
   assign dbg_state      = state;
endmodule

// File: tb/tb_sram_page_allocator.sv
// Randomised scoreboard bench for sram_page_allocator (16-page bank) against
// a free-list/in-use-set reference model.
module tb_sram_page_allocator;
   localparam int PN = 16;
   localparam int PW = 4;

   logic clk;
   logic rst;
   logic dbg_state;
   int   cyc;

   sram_page_allocator_if #(.PAGE_W(PW)) bus ();

   sram_page_allocator #(.PAGE_NUM(PN), .PAGE_W(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [PW-1:0] fl[$];
   bit            m_use [PN];
   bit            m_ready;
   int            init_n;
   logic [PW-1:0] last_grant;

   // ---------------- scoreboard ----------------
   // status entry: {ready, free_space[4:0], alloc_vld, alloc_page[3:0]}
   logic [10:0]   exp_q[$];
   logic [PW-1:0] grant_q[$];
   int            err_q[$];
   int            n_pass;
   int            n_total;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
   endtask

   function automatic logic [PW-1:0] pick_used();
      int cand[$];
      for (int i = 0; i < PN; i++) if (m_use[i]) cand.push_back(i);
      if (cand.size() == 0) return PW'($urandom_range(0, PN - 1));
      return PW'(cand[$urandom_range(0, cand.size() - 1)]);
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [10:0]   e;
      logic [PW-1:0] g;
      int            ec;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("ready", int'(bus.ready), int'(e[10]));
         check("free_space", int'(bus.free_space), int'(e[9:5]));
         check("alloc_vld", int'(bus.alloc_vld), int'(e[4]));
         if (e[4]) check("alloc_page", int'(bus.alloc_page), int'(e[3:0]));
      end
      if (!rst && bus.alloc_req && bus.alloc_vld) begin
         if (grant_q.size() == 0) begin
            check("unexpected_grant", 1, 0);
         end else begin
            g = grant_q.pop_front();
            check("grant_page", int'(bus.alloc_page), int'(g));
         end
      end
      if (bus.free_err === 1'b1) begin
         if (err_q.size() == 0) begin
            check("unexpected_free_err", 1, 0);
         end else begin
            ec = err_q.pop_front();
            check("free_err_cycle", cyc, ec);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input bit areq, input bit fvld, input logic [PW-1:0] fpage);
      bit            grant;
      bit            acc;
      bit            rej;
      logic [PW-1:0] g;
      bus.alloc_req = areq;
      bus.free_vld  = fvld;
      bus.free_page = fpage;
      exp_q.push_back({m_ready, 5'(fl.size()), m_ready && fl.size() != 0,
                       (fl.size() != 0) ? fl[0] : PW'(0)});
      grant = m_ready && areq && fl.size() != 0;
      acc   = m_ready && fvld && m_use[fpage];
      rej   = m_ready && fvld && !m_use[fpage];
      if (grant) begin
         g = fl.pop_front();
         grant_q.push_back(g);
         m_use[g]   = 1'b1;
         last_grant = g;
      end
      if (acc) begin
         m_use[fpage] = 1'b0;
         fl.push_back(fpage);
      end
      if (rej) err_q.push_back(cyc + 1);
      if (!m_ready) begin
         init_n++;
         if (init_n == PN) begin
            m_ready = 1'b1;
            for (int i = 0; i < PN; i++) fl.push_back(PW'(i));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.alloc_req = 1'b0;
      bus.free_vld  = 1'b0;
      bus.free_page = '0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      fl.delete();
      for (int i = 0; i < PN; i++) m_use[i] = 1'b0;
      m_ready = 1'b0;
      init_n  = 0;
   endtask

   task automatic rand_step();
      bit            fv;
      logic [PW-1:0] fp;
      fv = ($urandom_range(0, 1) == 1);
      fp = ($urandom_range(0, 3) != 0) ? pick_used() : PW'($urandom_range(0, PN - 1));
      step($urandom_range(0, 1) == 1, fv, fp);
   endtask

   initial begin
      logic [PW-1:0] lg;
      logic [PW-1:0] old;
      n_pass        = 0;
      n_total       = 0;
      rst           = 1'b1;
      bus.alloc_req = 1'b0;
      bus.free_vld  = 1'b0;
      bus.free_page = '0;
      m_ready       = 1'b0;
      init_n        = 0;
      last_grant    = '0;
      for (int i = 0; i < PN; i++) m_use[i] = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // INIT with random traffic that must be ignored, then the first RUN cycles
      for (int i = 0; i < PN + 2; i++) rand_step();

      // drain: 17 back-to-back requests
      for (int i = 0; i < PN + 1; i++) step(1, 0, '0);

      // recycle order and wrap
      step(0, 1, 4'd5);
      step(0, 1, 4'd3);
      step(0, 1, 4'd9);
      for (int i = 0; i < 3; i++) step(1, 0, '0);
      for (int i = 0; i < 20; i++) step(1, 1, pick_used());
      step(0, 0, '0);

      // illegal free: double free of a freshly allocated page, and page 7
      step(1, 0, '0);
      lg = last_grant;
      step(0, 1, lg);
      step(0, 1, lg);
      step(0, 0, '0);
      step(0, 1, 4'd7);
      step(0, 1, 4'd7);
      step(0, 0, '0);

      // simultaneous events at count 0 and count 4
      for (int i = 0; i < 3 * PN && fl.size() != 0; i++) step(1, 0, '0);
      step(1, 1, 4'd2);
      step(0, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, pick_used());
      step(1, 1, pick_used());
      step(0, 0, '0);
      step(1, 1, last_grant);
      step(0, 0, '0);

      // random soak
      for (int i = 0; i < 400; i++) rand_step();

      // full-bank free attempts always reject
      for (int i = 0; i < 3 * PN && fl.size() != PN; i++) step(0, 1, pick_used());
      for (int i = 0; i < 4; i++) step(0, 1, PW'($urandom_range(0, PN - 1)));

      // reset mid-run after six allocations
      for (int i = 0; i < 6; i++) step(1, 0, '0);
      old = last_grant;
      do_reset();
      for (int i = 0; i < PN + 2; i++) step(0, 0, '0);
      step(0, 1, old);
      step(0, 0, '0);
      for (int i = 0; i < 100; i++) rand_step();
      step(0, 0, '0);
      step(0, 0, '0);

      check("grant_q_left", grant_q.size(), 0);
      check("err_q_left", err_q.size(), 0);
      check("exp_q_left", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
